// File: rtl/mvm_seq_if.sv
// rtl/mvm_seq_if.sv - command, load, memory-control and result-stream bundle for mvm_seq (err present with MVM_SEQ_ERR_EN)
interface mvm_seq_if #(
  parameter int LOGK = 2
);
  logic              load_matrix;
  logic              load_vector;
  logic              start;
  logic              in_valid;
  logic              in_ready;
  logic [2*LOGK-1:0] addr_a;
  logic              wr_en_a;
  logic [LOGK-1:0]   addr_x;
  logic              wr_en_x;
  logic [LOGK-1:0]   addr_y;
  logic              wr_en_y;
  logic              clear_acc;
  logic              out_valid;
  logic              out_ready;
  logic              busy;
  logic              done;
`ifdef MVM_SEQ_ERR_EN
  logic              err;
`endif

  modport master (
    output load_matrix, load_vector, start, in_valid, out_ready,
    input  in_ready, addr_a, wr_en_a, addr_x, wr_en_x, addr_y, wr_en_y,
    input  clear_acc, out_valid, busy, done
`ifdef MVM_SEQ_ERR_EN
    , input err
`endif
  );

  modport slave (
    input  load_matrix, load_vector, start, in_valid, out_ready,
    output in_ready, addr_a, wr_en_a, addr_x, wr_en_x, addr_y, wr_en_y,
    output clear_acc, out_valid, busy, done
`ifdef MVM_SEQ_ERR_EN
    , output err
`endif
  );
endinterface

// File: rtl/mvm_seq.sv
// rtl/mvm_seq.sv - matrix-vector multiply sequencer driving external A/x/y memories and a MAC (optional MVM_SEQ_ERR_EN)
module mvm_seq #(
  parameter int K    = 4,
  parameter int LOGK = 2,
  parameter int PIPE = 2
) (
  input logic     clk,
  input logic     reset,
  mvm_seq_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_A, S_LOAD_X, S_COMPUTE, S_DRAIN, S_WRITE_Y, S_PREFETCH, S_OUTPUT
  } state_t;

  localparam int AW = 2 * LOGK;
  localparam int DW = (PIPE > 1) ? $clog2(PIPE) : 1;
  localparam logic [AW-1:0]   A_LAST = AW'(K * K - 1);
  localparam logic [AW-1:0]   A_ONE  = AW'(1);
  localparam logic [LOGK-1:0] X_LAST = LOGK'(K - 1);
  localparam logic [LOGK-1:0] X_ONE  = LOGK'(1);
  localparam logic [DW-1:0]   D_LAST = DW'((PIPE > 0) ? PIPE - 1 : 0);
  localparam logic [DW-1:0]   D_ONE  = DW'(1);

  state_t          state;
  logic [AW-1:0]   addr_a_q;
  logic [LOGK-1:0] addr_x_q;
  logic [LOGK-1:0] addr_y_q;
  logic [LOGK-1:0] row_q;
  logic [LOGK-1:0] idx_q;
  logic [DW-1:0]   dcnt_q;
  logic            in_ready_q;
  logic            out_valid_q;
  logic            busy_q;
  logic            done_q;
  logic            clear_q;
  logic            wr_y_q;
  logic [LOGK-1:0] addr_y_c;

  logic load_fire;
  logic out_fire;

  assign load_fire = in_ready_q & bus.in_valid;
  assign out_fire  = out_valid_q & bus.out_ready;

  // Look-ahead read address keeps a full-rate stream free of bubbles.
  always_comb begin
    addr_y_c = addr_y_q;
    if (state == S_OUTPUT) begin
      addr_y_c = idx_q;
      if (out_fire && idx_q != X_LAST) begin
        addr_y_c = idx_q + X_ONE;
      end
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.wr_en_a   = load_fire & (state == S_LOAD_A);
  assign bus.wr_en_x   = load_fire & (state == S_LOAD_X);
  assign bus.wr_en_y   = wr_y_q;
  assign bus.addr_a    = addr_a_q;
  assign bus.addr_x    = addr_x_q;
  assign bus.addr_y    = addr_y_c;
  assign bus.clear_acc = clear_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      addr_a_q    <= '0;
      addr_x_q    <= '0;
      addr_y_q    <= '0;
      row_q       <= '0;
      idx_q       <= '0;
      dcnt_q      <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      clear_q     <= 1'b1;
      wr_y_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            state  <= S_COMPUTE;
            busy_q <= 1'b1;
          end else if (bus.load_matrix) begin
            state      <= S_LOAD_A;
            busy_q     <= 1'b1;
            in_ready_q <= 1'b1;
          end else if (bus.load_vector) begin
            state      <= S_LOAD_X;
            busy_q     <= 1'b1;
            in_ready_q <= 1'b1;
          end
        end
        S_LOAD_A: begin
          if (load_fire) begin
            if (addr_a_q == A_LAST) begin
              state      <= S_IDLE;
              in_ready_q <= 1'b0;
              busy_q     <= 1'b0;
              addr_a_q   <= '0;
            end else begin
              addr_a_q <= addr_a_q + A_ONE;
            end
          end
        end
        S_LOAD_X: begin
          if (load_fire) begin
            if (addr_x_q == X_LAST) begin
              state      <= S_IDLE;
              in_ready_q <= 1'b0;
              busy_q     <= 1'b0;
              addr_x_q   <= '0;
            end else begin
              addr_x_q <= addr_x_q + X_ONE;
            end
          end
        end
        S_COMPUTE: begin
          // addr_x doubles as the column index j within the current row.
          if (addr_x_q == X_LAST) begin
            if (PIPE == 0) begin
              state    <= S_WRITE_Y;
              wr_y_q   <= 1'b1;
              addr_y_q <= row_q;
              clear_q  <= 1'b1;
            end else begin
              state   <= S_DRAIN;
              dcnt_q  <= '0;
              clear_q <= 1'b0;
            end
          end else begin
            addr_a_q <= addr_a_q + A_ONE;
            addr_x_q <= addr_x_q + X_ONE;
            clear_q  <= 1'b0;
          end
        end
        S_DRAIN: begin
          if (dcnt_q == D_LAST) begin
            state    <= S_WRITE_Y;
            wr_y_q   <= 1'b1;
            addr_y_q <= row_q;
            clear_q  <= 1'b1;
          end else begin
            dcnt_q <= dcnt_q + D_ONE;
          end
        end
        S_WRITE_Y: begin
          wr_y_q   <= 1'b0;
          addr_y_q <= '0;
          addr_x_q <= '0;
          if (row_q != X_LAST) begin
            row_q    <= row_q + X_ONE;
            addr_a_q <= addr_a_q + A_ONE;
            state    <= S_COMPUTE;
          end else begin
            row_q    <= '0;
            addr_a_q <= '0;
            state    <= S_PREFETCH;
          end
        end
        S_PREFETCH: begin
          state       <= S_OUTPUT;
          out_valid_q <= 1'b1;
          idx_q       <= '0;
        end
        S_OUTPUT: begin
          if (out_fire) begin
            if (idx_q == X_LAST) begin
              state       <= S_IDLE;
              out_valid_q <= 1'b0;
              done_q      <= 1'b1;
              busy_q      <= 1'b0;
              idx_q       <= '0;
            end else begin
              idx_q <= idx_q + X_ONE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef MVM_SEQ_ERR_EN
  logic err_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_q <= 1'b0;
    end else if (state != S_IDLE && (bus.load_matrix || bus.load_vector || bus.start)) begin
      err_q <= 1'b1;
    end
  end

  assign bus.err = err_q;
`endif

endmodule

// File: tb/tb_mvm_seq.sv
// tb/tb_mvm_seq.sv - self-checking bench for mvm_seq with an external memory/MAC model and reference product
module tb_mvm_seq;
  localparam int K      = 4;
  localparam int LOGK   = 2;
  localparam int PIPE   = 2;
  localparam int ROWLAT = K + PIPE + 1;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mvm_seq_if #(.LOGK(LOGK)) bus();

  mvm_seq #(.K(K), .LOGK(LOGK), .PIPE(PIPE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Environment: the memories and a MAC with a product register and an accumulator.
  logic [7:0]  din;
  logic [7:0]  mem_a [K*K];
  logic [7:0]  mem_x [K];
  logic [15:0] mem_y [K];
  logic [7:0]  rd_a, rd_x;
  logic [15:0] rd_y, prod, acc;

  always @(posedge clk) begin
    if (bus.wr_en_a) mem_a[bus.addr_a] <= din;
    if (bus.wr_en_x) mem_x[bus.addr_x] <= din;
    if (bus.wr_en_y) mem_y[bus.addr_y] <= acc;
    rd_a <= mem_a[bus.addr_a];
    rd_x <= mem_x[bus.addr_x];
    rd_y <= mem_y[bus.addr_y];
    if (bus.clear_acc) begin
      prod <= 16'd0;
      acc  <= 16'd0;
    end else begin
      prod <= 16'(rd_a) * 16'(rd_x);
      acc  <= acc + prod;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;
  int a_ref [K*K];
  int x_ref [K];

  typedef struct {
    bit st, lm, lv;
    bit busy, rdy, wa, wx;
  } cmd_vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".busy"}, bus.busy, 0);
    chk({tag, ".in_ready"}, bus.in_ready, 0);
    chk({tag, ".out_valid"}, bus.out_valid, 0);
    chk({tag, ".done"}, bus.done, 0);
    chk({tag, ".clear_acc"}, bus.clear_acc, 1);
    chk({tag, ".wr_en_a"}, bus.wr_en_a, 0);
    chk({tag, ".wr_en_x"}, bus.wr_en_x, 0);
    chk({tag, ".wr_en_y"}, bus.wr_en_y, 0);
    chk({tag, ".addr_a"}, bus.addr_a, 0);
    chk({tag, ".addr_x"}, bus.addr_x, 0);
    chk({tag, ".addr_y"}, bus.addr_y, 0);
`ifdef MVM_SEQ_ERR_EN
    chk({tag, ".err"}, bus.err, 0);
`endif
  endtask

  // gap_mode: 0 = in_valid always high, 1 = low every 3rd cycle, 2 = random
  task automatic do_load(input bit is_a, input int vals [K*K], input int gap_mode);
    int n = is_a ? K * K : K;
    int beat = 0;
    int c = 0;
    tick();
    if (is_a) bus.load_matrix = 1'b1;
    else      bus.load_vector = 1'b1;
    tick();
    bus.load_matrix = 1'b0;
    bus.load_vector = 1'b0;
    while (beat < n && c < 200) begin
      bus.in_valid = (gap_mode == 0) ? 1'b1 : (gap_mode == 1) ? (c % 3 != 2) : 1'($urandom_range(0, 1));
      din = 8'(vals[beat]);
      @(negedge clk);
      chk("load.in_ready", bus.in_ready, 1);
      chk("load.busy", bus.busy, 1);
      chk("load.wr_en", is_a ? bus.wr_en_a : bus.wr_en_x, bus.in_valid);
      chk("load.addr", is_a ? 32'(bus.addr_a) : 32'(bus.addr_x), beat);
      if (bus.in_valid) beat++;
      c++;
      tick();
    end
    if (beat < n) chk("load.timeout", beat, n);
    bus.in_valid = 1'b1;
    @(negedge clk);
    chk("load.end_in_ready", bus.in_ready, 0);
    chk("load.end_wr_en_a", bus.wr_en_a, 0);
    chk("load.end_wr_en_x", bus.wr_en_x, 0);
    chk("load.end_busy", bus.busy, 0);
    tick();
    bus.in_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (is_a) a_ref[i] = vals[i];
      else      x_ref[i] = vals[i];
    end
  endtask

  // mode: 0 = out_ready high, 1 = out_ready pattern 1,0,0,1, 2 = random
  task automatic do_compute(input int mode, input bit poke);
    int exp_y [K];
    int n, got, done_n, first_out, last_fire, r, p;
    for (int i = 0; i < K; i++) begin
      exp_y[i] = 0;
      for (int j = 0; j < K; j++) exp_y[i] += a_ref[i*K + j] * x_ref[j];
    end
    got = 0; done_n = -1; first_out = -1; last_fire = -1;
    tick();
    bus.start = 1'b1;
    @(negedge clk);
    chk("start.busy_in_idle", bus.busy, 0);
    tick();
    bus.start = 1'b0;
    n = 1;
    while (done_n < 0 && n < 300) begin
      case (mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = (n % 4 == 0) || (n % 4 == 3);
        default: bus.out_ready = 1'($urandom_range(0, 1));
      endcase
      bus.load_vector = poke && (n == K * ROWLAT + 3);
      @(negedge clk);
      if (n <= K * ROWLAT) begin
        r = (n - 1) / ROWLAT;
        p = (n - 1) % ROWLAT;
        chk("comp.busy", bus.busy, 1);
        if (p < K) begin
          chk("comp.addr_a", bus.addr_a, r * K + p);
          chk("comp.addr_x", bus.addr_x, p);
          chk("comp.clear_acc", bus.clear_acc, (p == 0));
          chk("comp.wr_en_y", bus.wr_en_y, 0);
        end else if (p < K + PIPE) begin
          chk("drain.clear_acc", bus.clear_acc, 0);
          chk("drain.addr_a", bus.addr_a, r * K + K - 1);
          chk("drain.wr_en_y", bus.wr_en_y, 0);
        end else begin
          chk("wry.wr_en_y", bus.wr_en_y, 1);
          chk("wry.addr_y", bus.addr_y, r);
          chk("wry.clear_acc", bus.clear_acc, 1);
        end
      end else if (n == K * ROWLAT + 1) begin
        chk("prefetch.out_valid", bus.out_valid, 0);
        chk("prefetch.addr_y", bus.addr_y, 0);
      end else if (bus.done) begin
        done_n = n;
        chk("done.out_valid", bus.out_valid, 0);
        chk("done.busy", bus.busy, 0);
      end else if (bus.out_valid) begin
        if (first_out < 0) first_out = n;
        if (got >= K) begin
          chk("out.extra_beat", got, K - 1);
        end else begin
          chk("out.data", rd_y, exp_y[got]);
          if (bus.out_ready) begin
            chk("out.addr_y_fire", bus.addr_y, (got < K - 1) ? got + 1 : K - 1);
            got++;
            last_fire = n;
          end else begin
            chk("out.addr_y_stall", bus.addr_y, got);
          end
        end
      end
      tick();
      n++;
    end
    bus.load_vector = 1'b0;
    chk("done.seen", (done_n >= 0), 1);
    chk("out.beats", got, K);
    chk("out.first_cycle", first_out, K * ROWLAT + 2);
    chk("done.cycle", done_n, last_fire + 1);
    if (mode == 0) chk("out.back_to_back", last_fire - first_out, K - 1);
    @(negedge clk);
    chk("done.one_cycle", bus.done, 0);
`ifdef MVM_SEQ_ERR_EN
    if (poke) chk("err.set", bus.err, 1);
`endif
  endtask

  cmd_vec_t vecs [8];
  int vals [K*K];

  initial begin
    vecs[0] = '{0, 0, 0, 0, 0, 0, 0};
    vecs[1] = '{1, 0, 0, 1, 0, 0, 0};
    vecs[2] = '{0, 1, 0, 1, 1, 1, 0};
    vecs[3] = '{0, 0, 1, 1, 1, 0, 1};
    vecs[4] = '{1, 1, 0, 1, 0, 0, 0};
    vecs[5] = '{0, 1, 1, 1, 1, 1, 0};
    vecs[6] = '{1, 1, 1, 1, 0, 0, 0};
    vecs[7] = '{1, 0, 1, 1, 0, 0, 0};

    bus.load_matrix = 1'b0;
    bus.load_vector = 1'b0;
    bus.start       = 1'b0;
    bus.in_valid    = 1'b0;
    bus.out_ready   = 1'b0;
    din             = 8'd0;

    #12;
    chk_reset_vals("reset");
    tick();
    reset = 1'b1;

    // Command priority in IDLE; each vector is aborted by a reset pulse.
    for (int v = 0; v < 8; v++) begin
      tick();
      bus.start       = vecs[v].st;
      bus.load_matrix = vecs[v].lm;
      bus.load_vector = vecs[v].lv;
      tick();
      bus.start       = 1'b0;
      bus.load_matrix = 1'b0;
      bus.load_vector = 1'b0;
      bus.in_valid    = 1'b1;
      @(negedge clk);
      chk($sformatf("cmd%0d.busy", v), bus.busy, vecs[v].busy);
      chk($sformatf("cmd%0d.in_ready", v), bus.in_ready, vecs[v].rdy);
      chk($sformatf("cmd%0d.wr_en_a", v), bus.wr_en_a, vecs[v].wa);
      chk($sformatf("cmd%0d.wr_en_x", v), bus.wr_en_x, vecs[v].wx);
      tick();
      bus.in_valid = 1'b0;
      reset = 1'b0;
      tick();
      reset = 1'b1;
    end

    for (int i = 0; i < K*K; i++) vals[i] = i + 1;
    do_load(1'b1, vals, 1);

    for (int i = 0; i < K*K; i++) vals[i] = (i / K == i % K) ? 2 : 0;
    do_load(1'b1, vals, 0);
    for (int i = 0; i < K*K; i++) vals[i] = (i < K) ? i + 1 : 0;
    do_load(1'b0, vals, 0);
    do_compute(0, 1'b1);
    do_compute(1, 1'b0);
`ifdef MVM_SEQ_ERR_EN
    chk("err.sticky", bus.err, 1);
`endif

    // Abort in the middle of row 2, then recompute from the same memories.
    tick();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (2 * ROWLAT + 2) tick();
    @(negedge clk);
    chk("abort.busy_before", bus.busy, 1);
    chk("abort.addr_a_before", bus.addr_a, 2 * K + 2);
    tick();
    #2;
    reset = 1'b0;
    #1;
    chk_reset_vals("async_reset");
    tick();
    reset = 1'b1;
    do_compute(0, 1'b0);

    for (int it = 0; it < 3; it++) begin
      for (int i = 0; i < K*K; i++) vals[i] = $urandom_range(0, 15);
      do_load(1'b1, vals, 2);
      for (int i = 0; i < K*K; i++) vals[i] = $urandom_range(0, 15);
      do_load(1'b0, vals, 2);
      do_compute(2, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
